// File: rtl/ls_mem_queue.sv
// ls_mem_queue: in-order load/store memory queue.
// Buffers address-unit results in a FIFO and performs one data-memory
// access at a time, in strict program order. Loads are broadcast on the
// CDB and held until granted; stores report completion with st_done/st_id.
`timescale 1ns/1ps
module ls_mem_queue #(
  parameter int DEPTH   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        in_valid,
  input  logic [22:0] in_entry,
  input  logic        in_store,
  input  logic [15:0] in_data,
  output logic        in_ack,
  output logic        full,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  output logic        cdb_req,
  output logic [22:0] cdb_data,
  input  logic        cdb_grant,
  output logic        st_done,
  output logic [3:0]  st_id
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ZERO_C  = (AW + 1)'(0);
  localparam logic [AW:0]   ONE_C   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_INC = AW'(1);
  localparam logic [CW-1:0] LAT_C   = CW'(MEM_LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BCAST = 2'd2
  } state_t;

  // FIFO storage (payload only; validity is tracked by the count)
  logic [22:0] r_q_entry [DEPTH];
  logic        r_q_store [DEPTH];
  logic [15:0] r_q_data  [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_in_ack;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_mem_addr;
  logic [15:0]   r_mem_wdata;
  logic          r_mem_we;
  logic          r_mem_re;
  logic          r_cdb_req;
  logic [22:0]   r_cdb_data;
  logic          r_st_done;
  logic [3:0]    r_st_id;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_nxt;
  logic [22:0]   w_head_entry;
  logic          w_head_store;
  logic [15:0]   w_head_data;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [15:0]   w_addr_nxt;
  logic [15:0]   w_wdata_nxt;
  logic          w_we_nxt;
  logic          w_re_nxt;
  logic          w_cdb_req_nxt;
  logic [22:0]   w_cdb_data_nxt;
  logic          w_st_done_nxt;
  logic [3:0]    w_st_id_nxt;

  // The in_ack term stops a second push while the producer is still
  // dropping in_valid after seeing the acknowledge.
  assign w_push = in_valid && !r_full && !r_in_ack;

  assign w_head_entry = r_q_entry[r_rd_ptr];
  assign w_head_store = r_q_store[r_rd_ptr];
  assign w_head_data  = r_q_data[r_rd_ptr];

  // Write the incoming entry into the slot at the write pointer
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_q_entry[r_wr_ptr] <= in_entry;
      r_q_store[r_wr_ptr] <= in_store;
      r_q_data[r_wr_ptr]  <= in_data;
    end
  end

  // Next occupancy: simultaneous push and pop leave it unchanged
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + ONE_C;
      2'b01:   w_count_nxt = r_count - ONE_C;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer, occupancy, full flag and acknowledge pulse registers
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= ZERO_C;
      r_full   <= 1'b0;
      r_in_ack <= 1'b0;
    end else begin
      r_wr_ptr <= w_push ? (r_wr_ptr + PTR_INC) : r_wr_ptr;
      r_rd_ptr <= w_pop  ? (r_rd_ptr + PTR_INC) : r_rd_ptr;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == DEPTH_C);
      r_in_ack <= w_push;
    end
  end

  // Access sequencer: next state, next registered outputs and pop request
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_addr_nxt     = r_mem_addr;
    w_wdata_nxt    = r_mem_wdata;
    w_we_nxt       = 1'b0;
    w_re_nxt       = 1'b0;
    w_cdb_req_nxt  = r_cdb_req;
    w_cdb_data_nxt = r_cdb_data;
    w_st_done_nxt  = 1'b0;
    w_st_id_nxt    = r_st_id;
    w_pop          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != ZERO_C) begin
          w_addr_nxt = w_head_entry[15:0];
          if (w_head_store) begin
            // Stores complete in a single cycle and free their slot at once
            w_wdata_nxt   = w_head_data;
            w_we_nxt      = 1'b1;
            w_st_done_nxt = 1'b1;
            w_st_id_nxt   = w_head_entry[19:16];
            w_pop         = 1'b1;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_re_nxt    = 1'b1;
            w_cnt_nxt   = LAT_C;
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Counter reaching zero on this edge is the edge where read data is valid
        if (r_cnt <= CNT_ONE) begin
          w_cnt_nxt      = CNT_ZERO;
          w_cdb_data_nxt = {w_head_entry[22:16], mem_rdata};
          w_cdb_req_nxt  = 1'b1;
          w_state_nxt    = ST_BCAST;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_ONE;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_BCAST: begin
        // The load stays at the head until the arbiter takes the result
        if (cdb_grant) begin
          w_cdb_req_nxt = 1'b0;
          w_pop         = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_state_nxt = ST_BCAST;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_cnt_nxt     = CNT_ZERO;
        w_cdb_req_nxt = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered memory / CDB / completion outputs
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state     <= ST_IDLE;
      r_cnt       <= CNT_ZERO;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 16'h0000;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_cdb_req   <= 1'b0;
      r_cdb_data  <= 23'h000000;
      r_st_done   <= 1'b0;
      r_st_id     <= 4'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_re    <= w_re_nxt;
      r_cdb_req   <= w_cdb_req_nxt;
      r_cdb_data  <= w_cdb_data_nxt;
      r_st_done   <= w_st_done_nxt;
      r_st_id     <= w_st_id_nxt;
    end
  end

  assign in_ack    = r_in_ack;
  assign full      = r_full;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign cdb_req   = r_cdb_req;
  assign cdb_data  = r_cdb_data;
  assign st_done   = r_st_done;
  assign st_id     = r_st_id;

endmodule

// File: tb/tb_ls_mem_queue.sv
// Bench for ls_mem_queue: memory model with real read latency, a
// scoreboard of expected completions in program order, a vector table
// and hand-written timing / corner-case sequences.
`timescale 1ns/1ps
module tb_ls_mem_queue;

  localparam int DEPTH   = 4;
  localparam int MEM_LAT = 2;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        in_valid;
  logic [22:0] in_entry;
  logic        in_store;
  logic [15:0] in_data;
  logic        in_ack;
  logic        full;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic        cdb_req;
  logic [22:0] cdb_data;
  logic        cdb_grant;
  logic        st_done;
  logic [3:0]  st_id;

  ls_mem_queue #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
    .CLK(CLK), .CLR(CLR),
    .in_valid(in_valid), .in_entry(in_entry), .in_store(in_store), .in_data(in_data),
    .in_ack(in_ack), .full(full),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata),
    .cdb_req(cdb_req), .cdb_data(cdb_data), .cdb_grant(cdb_grant),
    .st_done(st_done), .st_id(st_id)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        st;
    logic [2:0]  rd;
    logic [3:0]  rs;
    logic [15:0] addr;
    logic [15:0] val;   // store: write data; load: expected loaded value
  } rec_t;

  rec_t        sb[$];
  rec_t        vecs[8];
  int          total = 0;
  int          bad = 0;
  logic [15:0] mem  [256];
  logic [15:0] gold [256];
  int          rem = 0;
  logic [15:0] rd_addr = 16'h0000;
  int          grant_mode = 0;   // 0 never, 1 always, 2 random, 3 manual
  logic        man_grant = 1'b0;
  int          completions = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model, grant driver and scoreboard checking, all away from the rising edge
  always @(negedge CLK) begin : monitor
    rec_t e;
    logic g;
    if (mem_re) begin
      rem = MEM_LAT;
      rd_addr = mem_addr;
    end else if (rem > 0) begin
      rem--;
    end
    mem_rdata = (rem == 1) ? mem[rd_addr[7:0]] : 16'hDEAD;

    if (!CLR) check("st_done_vs_we", {31'd0, st_done}, {31'd0, mem_we});

    if (mem_we) begin
      mem[mem_addr[7:0]] = mem_wdata;
      completions++;
      if (sb.size() == 0) begin
        check("unexpected_store", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("store_in_order", {31'd0, e.st}, 32'd1);
        check("store_addr", {16'd0, mem_addr}, {16'd0, e.addr});
        check("store_wdata", {16'd0, mem_wdata}, {16'd0, e.val});
        check("store_id", {28'd0, st_id}, {28'd0, e.rs});
      end
    end
    if (mem_re) begin
      if (sb.size() == 0) begin
        check("unexpected_load", 32'd1, 32'd0);
      end else begin
        check("load_in_order", {31'd0, sb[0].st}, 32'd0);
        check("load_addr", {16'd0, mem_addr}, {16'd0, sb[0].addr});
      end
    end

    case (grant_mode)
      0:       g = 1'b0;
      1:       g = 1'b1;
      2:       g = ($urandom_range(0, 2) == 0);
      default: g = man_grant;
    endcase
    cdb_grant = g;
    if (cdb_req && g) begin
      completions++;
      if (sb.size() == 0) begin
        check("unexpected_cdb", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("cdb_in_order", {31'd0, e.st}, 32'd0);
        check("cdb_data", {9'd0, cdb_data}, {9'd0, e.rd, e.rs, e.val});
      end
    end
  end

  task automatic sb_add(input logic st, input logic [2:0] rd, input logic [3:0] rs,
                        input logic [15:0] addr, input logic [15:0] val);
    rec_t r;
    r.st = st; r.rd = rd; r.rs = rs; r.addr = addr; r.val = val;
    sb.push_back(r);
    if (st) gold[addr[7:0]] = val;
  endtask

  // Present one entry, wait for in_ack (bounded), optionally keep in_valid longer
  task automatic push(input logic st, input logic [2:0] rd, input logic [3:0] rs,
                      input logic [15:0] addr, input logic [15:0] val, input int hold_extra);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_entry = {rd, rs, addr};
    in_store = st;
    in_data  = st ? val : 16'($urandom);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge CLK); #1;
      if (in_ack) ok = 1'b1;
    end
    if (ok) sb_add(st, rd, rs, addr, val);
    else check("ack_timeout", 32'd0, 32'd1);
    repeat (hold_extra) begin @(posedge CLK); #1; end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge CLK);
    check("drain_empty", sb.size(), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ack"}, {31'd0, in_ack}, 32'd0);
    check({tag, "_full"}, {31'd0, full}, 32'd0);
    check({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_re"}, {31'd0, mem_re}, 32'd0);
    check({tag, "_cdb_req"}, {31'd0, cdb_req}, 32'd0);
    check({tag, "_cdb_data"}, {9'd0, cdb_data}, 32'd0);
    check({tag, "_st_done"}, {31'd0, st_done}, 32'd0);
    check({tag, "_st_id"}, {28'd0, st_id}, 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic        acked;
    logic [15:0] a;
    logic [15:0] v;
    int          c0;

    for (int i = 0; i < 256; i++) begin
      mem[i]  = {8'hC0, 8'(i)};
      gold[i] = {8'hC0, 8'(i)};
    end
    mem[16'h0010]  = 16'h1234;
    gold[16'h0010] = 16'h1234;

    vecs[0] = '{1'b1, 3'd3, 4'd5,  16'h0040, 16'hBEEF};
    vecs[1] = '{1'b0, 3'd2, 4'd7,  16'h0040, 16'hBEEF};
    vecs[2] = '{1'b0, 3'd1, 4'd2,  16'h0010, 16'h1234};
    vecs[3] = '{1'b1, 3'd0, 4'd9,  16'h0010, 16'h0F0F};
    vecs[4] = '{1'b0, 3'd6, 4'd3,  16'h0010, 16'h0F0F};
    vecs[5] = '{1'b0, 3'd7, 4'd15, 16'h0022, 16'hC022};
    vecs[6] = '{1'b1, 3'd4, 4'd1,  16'h00FF, 16'h8001};
    vecs[7] = '{1'b0, 3'd5, 4'd0,  16'h00FF, 16'h8001};

    CLR = 1'b1; in_valid = 1'b0; in_entry = 23'd0; in_store = 1'b0; in_data = 16'd0;
    mem_rdata = 16'h0000; cdb_grant = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    CLR = 1'b0;
    @(posedge CLK); #1;
    check_all_zero("post_reset");

    // Single store: outputs one cycle after in_ack
    grant_mode = 1;
    push(1'b1, 3'd3, 4'd5, 16'h0040, 16'hBEEF, 0);
    @(posedge CLK); #1;
    check("ss_mem_we", {31'd0, mem_we}, 32'd1);
    check("ss_mem_addr", {16'd0, mem_addr}, 32'h0040);
    check("ss_mem_wdata", {16'd0, mem_wdata}, 32'hBEEF);
    check("ss_st_done", {31'd0, st_done}, 32'd1);
    check("ss_st_id", {28'd0, st_id}, 32'd5);
    check("ss_ack_pulse", {31'd0, in_ack}, 32'd0);
    @(posedge CLK); #1;
    check("ss_we_drop", {31'd0, mem_we}, 32'd0);
    drain();

    // Single load with MEM_LAT=2, grant withheld for 3 cycles
    grant_mode = 3; man_grant = 1'b0;
    push(1'b0, 3'd2, 4'd7, 16'h0010, 16'h1234, 0);
    @(posedge CLK); #1;
    check("sl_mem_re", {31'd0, mem_re}, 32'd1);
    check("sl_mem_addr", {16'd0, mem_addr}, 32'h0010);
    @(posedge CLK); #1;
    check("sl_re_drop", {31'd0, mem_re}, 32'd0);
    check("sl_req_early", {31'd0, cdb_req}, 32'd0);
    @(posedge CLK); #1;
    check("sl_req_rise", {31'd0, cdb_req}, 32'd1);
    check("sl_cdb_data", {9'd0, cdb_data}, {9'd0, 3'd2, 4'd7, 16'h1234});
    @(posedge CLK); #1;
    check("sl_req_hold1", {31'd0, cdb_req}, 32'd1);
    @(posedge CLK); #1;
    check("sl_req_hold2", {31'd0, cdb_req}, 32'd1);
    check("sl_data_hold", {9'd0, cdb_data}, {9'd0, 3'd2, 4'd7, 16'h1234});
    man_grant = 1'b1;
    @(posedge CLK); #1;
    man_grant = 1'b0;
    check("sl_req_drop", {31'd0, cdb_req}, 32'd0);
    drain();

    // Vector table, immediate grant
    grant_mode = 1;
    for (int i = 0; i < 8; i++)
      push(vecs[i].st, vecs[i].rd, vecs[i].rs, vecs[i].addr, vecs[i].val, 0);
    drain();

    // Fill: four loads with no grant, fifth must wait for the first grant
    grant_mode = 0;
    for (int k = 0; k < DEPTH; k++) begin
      a = 16'h0050 + 16'(k);
      push(1'b0, 3'(k), 4'(k + 8), a, gold[a[7:0]], 0);
    end
    check("fill_full", {31'd0, full}, 32'd1);
    in_valid = 1'b1; in_store = 1'b0; in_entry = {3'd6, 4'd12, 16'h0058}; in_data = 16'h0000;
    acked = 1'b0;
    repeat (6) begin @(posedge CLK); #1; acked = acked | in_ack; end
    check("fill_blocked", {31'd0, acked}, 32'd0);
    check("fill_still_full", {31'd0, full}, 32'd1);
    grant_mode = 1;
    for (int i = 0; i < 60 && !acked; i++) begin
      @(posedge CLK); #1;
      if (in_ack) acked = 1'b1;
    end
    check("fill_fifth_acked", {31'd0, acked}, 32'd1);
    if (acked) sb_add(1'b0, 3'd6, 4'd12, 16'h0058, gold[8'h58]);
    in_valid = 1'b0;
    drain();

    // Double-push guard: in_valid held one extra cycle
    c0 = completions;
    push(1'b1, 3'd1, 4'd6, 16'h0060, 16'h7777, 1);
    drain();
    check("single_entry", completions - c0, 32'd1);

    // Wrap and ordering: alternating load/store, random grant delay
    grant_mode = 2;
    for (int i = 0; i < 10; i++) begin
      a = 16'h0030 + 16'($urandom_range(0, 3));
      if (i % 2 == 1) begin
        v = 16'($urandom);
        push(1'b1, 3'($urandom_range(0, 7)), 4'(i), a, v, 0);
      end else begin
        push(1'b0, 3'($urandom_range(0, 7)), 4'(i), a, gold[a[7:0]], 0);
      end
    end
    drain();

    // Reset in the middle of a load's WAIT phase
    grant_mode = 0;
    push(1'b0, 3'd5, 4'd11, 16'h0010, gold[8'h10], 0);
    @(posedge CLK); #1;
    check("rw_mem_re", {31'd0, mem_re}, 32'd1);
    @(posedge CLK); #1;
    CLR = 1'b1;
    #1;
    check_all_zero("rw");
    sb.delete();
    rem = 0;
    @(posedge CLK); #1;
    CLR = 1'b0;
    grant_mode = 1;
    c0 = completions;
    acked = 1'b0;
    repeat (10) begin
      @(posedge CLK); #1;
      acked = acked | cdb_req | st_done | mem_re | mem_we;
    end
    check("rw_quiet", {31'd0, acked}, 32'd0);
    check("rw_no_completion", completions - c0, 32'd0);
    push(1'b1, 3'd2, 4'd4, 16'h0070, 16'hA5A5, 0);
    drain();
    check("rw_final_empty", {31'd0, full}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
